// File: rtl/prbs_xnor_checker.sv
// Serial receive-side checker for an XNOR-feedback PRBS stream: self-synchronises,
// declares lock after a run of correct predictions, and counts bit errors while locked.
module prbs_xnor_checker #(
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned TAP_A      = 7,
  parameter int unsigned TAP_B      = 6,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_ERR = 8,
  parameter int unsigned ERRCNT_W   = 16
) (
  input  logic                CLK,
  input  logic                RN,
  inout  wire                 VDD,
  inout  wire                 VSS,
  input  logic                EN,
  input  logic                D,
  input  logic                CLR,
  output logic                LOCKED,
  output logic                ERR,
  output logic [ERRCNT_W-1:0] ERR_CNT,
  output logic                SAT
);

  localparam int unsigned FILL_W = $clog2(WIDTH + 1);
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    match_q, match_d;
  logic [CNT_W-1:0]    bucket_q, bucket_d;
  logic                err_q, err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                sat_q, sat_d;

  logic full;
  logic pred;
  logic mis;
  logic check;
  logic hist_ones;
  logic inc;

  // Supply pins are connection-only; this net exists only so they are referenced.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // Prediction from the received-data history and qualification of the compare.
  always_comb begin
    full      = (fill_q == FILL_W'(WIDTH));
    pred      = ~(hist_q[TAP_A-1] ^ hist_q[TAP_B-1]);
    mis       = D ^ pred;
    check     = EN & full;
    hist_ones = &hist_q;
  end

  // History shift register and fill counter, always loaded from received data.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (EN) begin
      hist_d = {hist_q[WIDTH-2:0], D};
      if (!full) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // Lock FSM: match run counter in SEARCH, leaky error bucket in LOCKED.
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    bucket_d = bucket_q;
    err_d    = 1'b0;
    inc      = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (check) begin
          if (mis || hist_ones) begin
            match_d = '0;
          end else if (match_q == CNT_W'(LOCK_CNT - 1)) begin
            state_d  = ST_LOCKED;
            match_d  = '0;
            bucket_d = '0;
          end else begin
            match_d = match_q + CNT_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (check) begin
          if (mis) begin
            err_d    = 1'b1;
            inc      = 1'b1;
            bucket_d = bucket_q + CNT_W'(1);
            if (bucket_q == CNT_W'(UNLOCK_ERR - 1)) begin
              state_d = ST_SEARCH;
              match_d = '0;
            end
          end else if (bucket_q != '0) begin
            bucket_d = bucket_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // Saturating error counter with sticky saturation flag; clear wins over increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    sat_d     = sat_q;
    if (CLR) begin
      err_cnt_d = '0;
      sat_d     = 1'b0;
    end else begin
      if (inc && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + ERRCNT_W'(1);
      end
      sat_d = sat_q | (&err_cnt_d);
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_SEARCH;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      bucket_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      bucket_q  <= bucket_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign LOCKED  = (state_q == ST_LOCKED);
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;
  assign SAT     = sat_q;

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// Directed bench for prbs_xnor_checker: reference model feeds an expected-output queue,
// plus directed checks of lock latency, error spacing, saturation and reset behaviour.
module tb_prbs_xnor_checker;

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic        sat;
    logic [3:0]  cnt4;
    logic        sat4;
  } obs_t;

  logic        clk;
  logic        rn;
  logic        en;
  logic        d;
  logic        clr;
  logic        locked, err, sat;
  logic [15:0] err_cnt;
  logic        locked4, err4, sat4;
  logic [3:0]  err_cnt4;
  wire         vdd = 1'b1;
  wire         vss = 1'b0;

  prbs_xnor_checker #(.ERRCNT_W(16)) u_dut (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .EN(en), .D(d), .CLR(clr),
    .LOCKED(locked), .ERR(err), .ERR_CNT(err_cnt), .SAT(sat)
  );

  prbs_xnor_checker #(.ERRCNT_W(4)) u_dut4 (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .EN(en), .D(d), .CLR(clr),
    .LOCKED(locked4), .ERR(err4), .ERR_CNT(err_cnt4), .SAT(sat4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  obs_t exp_q[$];
  int   err_pos_q[$];

  // reference model state
  bit [6:0] m_hist;
  int       m_fill, m_match, m_bucket, m_cnt, m_cnt4;
  bit       m_locked, m_err, m_sat, m_sat4;

  // PRBS generator state
  bit [6:0] g;

  function automatic obs_t observed();
    obs_t o;
    o.locked = locked; o.err = err; o.cnt = err_cnt; o.sat = sat;
    o.cnt4 = err_cnt4; o.sat4 = sat4;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_hist = '0; m_fill = 0; m_match = 0; m_bucket = 0; m_cnt = 0; m_cnt4 = 0;
    m_locked = 0; m_err = 0; m_sat = 0; m_sat4 = 0;
  endtask

  task automatic model_step(input logic e, input logic b, input logic c);
    bit pred, mis, inc;
    inc   = 0;
    m_err = 0;
    if (e) begin
      if (m_fill == 7) begin
        pred = ~(m_hist[6] ^ m_hist[5]);
        mis  = (b != pred);
        if (!m_locked) begin
          if (mis || m_hist == 7'h7f) m_match = 0;
          else begin
            m_match++;
            if (m_match == 16) begin m_locked = 1; m_match = 0; m_bucket = 0; end
          end
        end else begin
          if (mis) begin
            m_err = 1; inc = 1; m_bucket++;
            if (m_bucket == 8) begin m_locked = 0; m_match = 0; end
          end else if (m_bucket > 0) m_bucket--;
        end
      end else m_fill++;
      m_hist = {m_hist[5:0], b};
    end
    if (c) begin
      m_cnt = 0; m_cnt4 = 0; m_sat = 0; m_sat4 = 0;
    end else if (inc) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
      if (m_cnt == 65535) m_sat = 1;
      if (m_cnt4 == 15) m_sat4 = 1;
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.locked = m_locked; o.err = m_err; o.cnt = 16'(m_cnt); o.sat = m_sat;
    o.cnt4 = 4'(m_cnt4); o.sat4 = m_sat4;
    return o;
  endfunction

  task automatic gen_bit(output logic b);
    b = ~(g[6] ^ g[5]);
    g = {g[5:0], b};
  endtask

  // Drive one cycle, queue the model's expectation, compare after the edge.
  task automatic step(input logic e, input logic b, input logic c);
    obs_t x;
    @(negedge clk);
    en = e; d = b; clr = c;
    model_step(e, b, c);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk("outputs", 32'(observed()), 32'(x));
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; clr = 1'b0; d = 1'b0;
    #2;
    rn = 1'b0;
    #1;
    model_reset();
    chk("reset_outputs", 32'(observed()), 32'(0));
    @(negedge clk);
    rn = 1'b1;
  endtask

  // Run PRBS with EN=1 until lock; returns number of bits used (budget 60).
  task automatic run_to_lock(output int n);
    logic b;
    n = 0;
    while (!locked && n < 60) begin
      gen_bit(b);
      step(1'b1, b, 1'b0);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b, r;
    int   n, lock_cycles, unlock_n, en_bits;
    bit   unlocked;
    rn = 1'b0; en = 1'b0; d = 1'b0; clr = 1'b0;
    g = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(observed()), 32'(0));
    @(negedge clk);
    rn = 1'b1;

    // 1: clean lock from 7'h00 seed
    run_to_lock(n);
    chk("lock_latency", 32'(n), 32'd23);
    for (int i = 0; i < 500; i++) begin gen_bit(b); step(1'b1, b, 1'b0); end
    chk("clean_err_cnt", 32'(err_cnt), 32'd0);
    chk("clean_locked", 32'(locked), 32'd1);

    // 2: single channel flip yields three spaced error pulses
    for (int i = 0; i < 30; i++) begin
      gen_bit(b);
      if (i == 5) begin
        b = ~b;
        err_pos_q.push_back(5); err_pos_q.push_back(11); err_pos_q.push_back(12);
      end
      step(1'b1, b, 1'b0);
      if (err) begin
        if (err_pos_q.size() == 0) chk("err_pos_extra", 32'(i), 32'hffff_ffff);
        else chk("err_pos", 32'(i), 32'(err_pos_q.pop_front()));
      end
    end
    chk("err_pos_missing", 32'(err_pos_q.size()), 32'd0);
    chk("flip_err_cnt", 32'(err_cnt), 32'd3);
    chk("flip_locked", 32'(locked), 32'd1);

    // 6: asynchronous reset while locked, then full relock
    do_reset();
    run_to_lock(n);
    chk("relock_after_reset", 32'(n), 32'd23);

    // 4: random data forces loss of lock, PRBS resumes and relocks
    unlocked = 0;
    unlock_n = 0;
    while (!unlocked && unlock_n < 4000) begin
      r = 1'($urandom_range(1, 0));
      step(1'b1, r, 1'b0);
      unlock_n++;
      if (!locked) unlocked = 1;
    end
    chk("unlock_seen", 32'(unlocked), 32'd1);
    chk("unlock_cnt_ge8", 32'(err_cnt >= 16'd8), 32'd1);
    run_to_lock(n);
    chk("relock_within_23", 32'(n <= 23), 32'd1);

    // 3: stuck-at-1 never locks
    do_reset();
    lock_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (locked) lock_cycles++;
    end
    chk("stuck1_lock_cycles", 32'(lock_cycles), 32'd0);
    chk("stuck1_err_cnt", 32'(err_cnt), 32'd0);

    // 5: EN gaps give the same enabled-bit lock count
    do_reset();
    g = '0;
    en_bits = 0;
    for (int k = 0; k < 90 && !locked; k++) begin
      if ((k % 3) == 2) begin
        r = 1'($urandom_range(1, 0));
        step(1'b0, r, 1'b0);
      end else begin
        gen_bit(b);
        step(1'b1, b, 1'b0);
        en_bits++;
      end
    end
    chk("gap_lock_bits", 32'(en_bits), 32'd23);

    // 5: 21 mismatches saturate the narrow counter, then CLR wins over an increment
    for (int f = 0; f < 7; f++) begin
      for (int i = 0; i < 12; i++) begin
        gen_bit(b);
        if (i == 0) b = ~b;
        step(1'b1, b, 1'b0);
      end
    end
    chk("sat_cnt16", 32'(err_cnt), 32'd21);
    chk("sat_cnt4", 32'(err_cnt4), 32'hf);
    chk("sat_flag4", 32'(sat4), 32'd1);
    chk("sat_locked", 32'(locked), 32'd1);
    gen_bit(b);
    step(1'b1, ~b, 1'b1);
    chk("clr_cnt4", 32'(err_cnt4), 32'd0);
    chk("clr_sat4", 32'(sat4), 32'd0);
    chk("clr_cnt16", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 10; i++) begin gen_bit(b); step(1'b1, b, 1'b0); end
    chk("post_clr_cnt", 32'(err_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
